// File: rtl/aes_pkg.sv
// Shared AES definitions: block width, AES-128 core pipeline latency and block type.
// Ports: none (package only).
// Imported by the result buffer, its interface and its FIFO.
package aes_pkg;
   localparam int AES_BLOCK_W     = 128;
   localparam int AES_128_LATENCY = 21;

   typedef logic [AES_BLOCK_W-1:0] aes_block_t;
endpackage

// File: rtl/aes_result_buffer_if.sv
// Bundle of the result buffer's handshake and data signals.
// Ports: issue_valid/issue_ready (credit to feeder), core_out (core result bus),
//        m_valid/m_data/m_ready (output stream), occupancy, overflow_err.
interface aes_result_buffer_if
   import aes_pkg::*;
#(
   parameter int WIDTH = AES_BLOCK_W,
   parameter int DEPTH = 32
);
   localparam int OCC_W = $clog2(DEPTH) + 1;

   logic             issue_valid;
   logic             issue_ready;
   logic [WIDTH-1:0] core_out;
   logic             m_valid;
   logic [WIDTH-1:0] m_data;
   logic             m_ready;
   logic [OCC_W-1:0] occupancy;
   logic             overflow_err;

   // Buffer side
   modport slave (
      input  issue_valid, core_out, m_ready,
      output issue_ready, m_valid, m_data, occupancy, overflow_err
   );

   // Feeder / core / consumer side
   modport master (
      output issue_valid, core_out, m_ready,
      input  issue_ready, m_valid, m_data, occupancy, overflow_err
   );
endinterface

// File: rtl/aes_buf_fifo.sv
// Show-ahead FIFO; zero-cycle read (rd_data = head), write visible one cycle later.
// Ports: clk, rst (async high), wr_en/wr_data, rd_en/rd_data, full, empty.
// Writes while full are dropped unless a read happens in the same cycle.
module aes_buf_fifo
   import aes_pkg::*;
#(
   parameter int WIDTH = AES_BLOCK_W,
   parameter int DEPTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   // Address bits plus a wrap bit; full/empty differ only in the wrap bit.
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_wr;
   logic             do_rd;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign do_rd   = rd_en & ~empty;
   // A read in the same cycle frees the slot the write lands in.
   assign do_wr   = wr_en & (~full | do_rd);
   assign rd_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // Storage is intentionally not reset.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
   end
endmodule

// File: rtl/aes_result_buffer.sv
// Captures AES core results for accepted blocks into a FIFO and streams them out.
// Ports: clk, rst (async high), bus (slave modport: credit issue, core_out, output stream).
// Credits cover in-flight plus buffered blocks, so a capture always finds a free slot.
module aes_result_buffer
   import aes_pkg::*;
#(
   parameter int LATENCY = AES_128_LATENCY,
   parameter int DEPTH   = 32,
   parameter int WIDTH   = AES_BLOCK_W
) (
   input  logic                clk,
   input  logic                rst,
   aes_result_buffer_if.slave  bus
);
   localparam int OCC_W = $clog2(DEPTH) + 1;

   logic [LATENCY-1:0] vld_line;
   logic [OCC_W-1:0]   occ_q;
   logic               ovf_q;
   logic               fire;
   logic               cap;
   logic               pop;
   logic               full;
   logic               empty;

   assign bus.issue_ready  = (occ_q < OCC_W'(DEPTH));
   assign fire             = bus.issue_valid & bus.issue_ready;
   // Tail of the delay line lines up with the core output of a fired block.
   assign cap              = vld_line[LATENCY-1];
   assign bus.m_valid      = ~empty;
   assign pop              = bus.m_valid & bus.m_ready;
   assign bus.occupancy    = occ_q;
   assign bus.overflow_err = ovf_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_line <= '0;
         occ_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         vld_line[0] <= fire;
         for (int i = 1; i < LATENCY; i++) begin
            vld_line[i] <= vld_line[i-1];
         end
         // Capture only moves an entry from in-flight to buffered.
         case ({fire, pop})
            2'b10:   occ_q <= occ_q + OCC_W'(1);
            2'b01:   occ_q <= occ_q - OCC_W'(1);
            default: occ_q <= occ_q;
         endcase
         // Reachable only when the feeder ignored issue_ready.
         if (cap && full && !pop) ovf_q <= 1'b1;
      end
   end

   aes_buf_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (cap),
      .wr_data (bus.core_out),
      .rd_en   (pop),
      .rd_data (bus.m_data),
      .full    (full),
      .empty   (empty)
   );
endmodule

// File: tb/tb_aes_result_buffer.sv
// Directed bench for aes_result_buffer with a model AES pipeline and a FIFO scoreboard.
// Ports: none (top-level bench).
// Phase table drives credit/fill/drain; hand sequences cover latency, reset and overflow.
module tb_aes_result_buffer;
   localparam int LAT   = 21;
   localparam int DEPTH = 32;
   localparam int W     = 128;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [W-1:0] blk = '0;

   int checks = 0;
   int errors = 0;
   int fires  = 0;
   int pops   = 0;
   int cyc    = 0;
   int max_occ = 0;
   int first_pop_cyc = -1;
   int last_pop_cyc  = -1;
   bit track_first   = 1'b0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] pipe [LAT];

   aes_result_buffer_if #(.WIDTH(W), .DEPTH(DEPTH)) bus ();

   aes_result_buffer #(
      .LATENCY (LAT),
      .DEPTH   (DEPTH),
      .WIDTH   (W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Model core: whatever is loaded appears on core_out LAT cycles later.
   always @(posedge clk) begin
      for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
      pipe[0] <= blk;
      cyc <= cyc + 1;
   end
   assign bus.core_out = pipe[LAT-1];

   task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", nm, act, req);
      end
   endtask

   // Scoreboard: push on fire, compare head on pop.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_q.delete();
      end else begin
         if (bus.issue_valid && bus.issue_ready) begin
            exp_q.push_back(blk);
            fires++;
         end
         if (bus.m_valid && bus.m_ready) begin
            pops++;
            last_pop_cyc = cyc;
            if (track_first) begin
               first_pop_cyc = cyc;
               track_first   = 1'b0;
            end
            if (exp_q.size() == 0) begin
               check("pop_without_entry", 1, 0);
            end else begin
               check("m_data_order", bus.m_data, exp_q.pop_front());
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      blk = {$urandom, $urandom, $urandom, $urandom};
      if (int'(bus.occupancy) > max_occ) max_occ = int'(bus.occupancy);
   endtask

   typedef struct {
      string name;
      int    cycles;
      bit    iv;
      bit    mr;
      int    exp_fires;
      int    exp_occ;
      bit    exp_ir;
      bit    exp_mv;
   } row_t;

   row_t tbl[6];

   initial begin
      int f0, p0;
      logic [W-1:0] v;

      tbl[0] = '{"burst",   40, 1'b1, 1'b0, 32, 32, 1'b0, 1'b1};
      tbl[1] = '{"settle",  25, 1'b0, 1'b0,  0, 32, 1'b0, 1'b1};
      tbl[2] = '{"pop1",     1, 1'b0, 1'b1,  0, 31, 1'b1, 1'b1};
      tbl[3] = '{"refill",   3, 1'b1, 1'b0,  1, 32, 1'b0, 1'b1};
      tbl[4] = '{"settle2", 25, 1'b0, 1'b0,  0, 32, 1'b0, 1'b1};
      tbl[5] = '{"drain",   32, 1'b0, 1'b1,  0,  0, 1'b1, 1'b0};

      bus.issue_valid = 1'b0;
      bus.m_ready     = 1'b0;

      // Reset values
      #2;
      check("rst_issue_ready", bus.issue_ready, 1);
      check("rst_m_valid", bus.m_valid, 0);
      check("rst_occupancy", bus.occupancy, 0);
      check("rst_overflow", bus.overflow_err, 0);
      step();
      step();
      rst = 1'b0;
      step();

      // Single block: latency LAT+1 from fire to m_valid
      v = 128'h3925841d02dc09fbdc118597196a0b32;
      bus.issue_valid = 1'b1;
      blk = v;
      step();
      bus.issue_valid = 1'b0;
      check("single_occ_after_fire", bus.occupancy, 1);
      repeat (LAT - 1) step();
      check("single_not_early", bus.m_valid, 0);
      step();
      check("single_m_valid", bus.m_valid, 1);
      check("single_m_data", bus.m_data, v);
      check("single_occ", bus.occupancy, 1);
      repeat (3) step();
      check("single_data_stable", bus.m_data, v);
      bus.m_ready = 1'b1;
      step();
      bus.m_ready = 1'b0;
      check("single_popped_mv", bus.m_valid, 0);
      check("single_popped_occ", bus.occupancy, 0);

      // Burst / fill / pop / refill / drain
      foreach (tbl[r]) begin
         f0 = fires;
         bus.issue_valid = tbl[r].iv;
         bus.m_ready     = tbl[r].mr;
         repeat (tbl[r].cycles) step();
         bus.issue_valid = 1'b0;
         bus.m_ready     = 1'b0;
         check({tbl[r].name, "_fires"}, fires - f0, tbl[r].exp_fires);
         check({tbl[r].name, "_occ"}, bus.occupancy, tbl[r].exp_occ);
         check({tbl[r].name, "_issue_ready"}, bus.issue_ready, tbl[r].exp_ir);
         check({tbl[r].name, "_m_valid"}, bus.m_valid, tbl[r].exp_mv);
         check({tbl[r].name, "_overflow"}, bus.overflow_err, 0);
      end
      check("drain_sb_empty", exp_q.size(), 0);

      // Full-rate streaming
      f0 = fires;
      p0 = pops;
      max_occ = 0;
      track_first = 1'b1;
      bus.m_ready = 1'b1;
      bus.issue_valid = 1'b1;
      repeat (100) step();
      bus.issue_valid = 1'b0;
      repeat (30) step();
      bus.m_ready = 1'b0;
      check("stream_fires", fires - f0, 100);
      check("stream_pops", pops - p0, 100);
      check("stream_back_to_back", last_pop_cyc - first_pop_cyc, 99);
      check("stream_max_occ_ok", (max_occ <= LAT + 1), 1);
      check("stream_end_occ", bus.occupancy, 0);

      // Asynchronous reset with blocks in flight
      bus.issue_valid = 1'b1;
      repeat (10) step();
      bus.issue_valid = 1'b0;
      repeat (5) step();
      check("inflight_occ", bus.occupancy, 10);
      #3;
      rst = 1'b1;
      #1;
      check("arst_occ", bus.occupancy, 0);
      check("arst_issue_ready", bus.issue_ready, 1);
      check("arst_m_valid", bus.m_valid, 0);
      #2;
      rst = 1'b0;
      repeat (30) step();
      check("post_rst_no_capture", bus.m_valid, 0);
      check("post_rst_occ", bus.occupancy, 0);

      // Forced overflow: fill, then inject a fire the credit logic refused
      bus.issue_valid = 1'b1;
      repeat (DEPTH) step();
      bus.issue_valid = 1'b0;
      repeat (25) step();
      check("ovf_pre_full_occ", bus.occupancy, DEPTH);
      check("ovf_pre_flag", bus.overflow_err, 0);
      force dut.fire = 1'b1;
      step();
      release dut.fire;
      repeat (25) step();
      check("ovf_set", bus.overflow_err, 1);
      repeat (5) step();
      check("ovf_sticky", bus.overflow_err, 1);
      p0 = pops;
      bus.m_ready = 1'b1;
      repeat (DEPTH) step();
      bus.m_ready = 1'b0;
      check("ovf_drain_count", pops - p0, DEPTH);
      check("ovf_no_extra_entry", bus.m_valid, 0);
      check("ovf_sb_empty", exp_q.size(), 0);
      check("ovf_sticky_after_drain", bus.overflow_err, 1);
      rst = 1'b1;
      #1;
      check("ovf_cleared_by_rst", bus.overflow_err, 0);
      rst = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
